// File: rtl/fft_dmem_arbiter.sv
// rtl/fft_dmem_arbiter.sv - dmem port arbiter between the openMSP430 core and the FFT accelerator master
// The core always owns the RAM when it asks; accelerator writes are posted, and reads are single outstanding.
module fft_dmem_arbiter #(
  parameter int AW         = 10,
  parameter int WBUF_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic                            mclk,
  input  logic                            reset_n,
  input  logic [AW-1:0]                   cpu_addr,
  input  logic                            cpu_cen,
  input  logic [1:0]                      cpu_wen,
  input  logic [15:0]                     cpu_din,
  output logic [15:0]                     cpu_dout,
  input  logic                            acc_valid,
  output logic                            acc_ready,
  input  logic                            acc_we,
  input  logic [AW-1:0]                   acc_addr,
  input  logic [15:0]                     acc_wdata,
  output logic                            acc_rvalid,
  output logic [15:0]                     acc_rdata,
  output logic [AW-1:0]                   ram_addr,
  output logic                            ram_cen,
  output logic [1:0]                      ram_wen,
  output logic [15:0]                     ram_din,
  input  logic [15:0]                     ram_dout,
  output logic [$clog2(WBUF_DEPTH):0]     wbuf_level,
  output logic [CNT_W-1:0]                stall_cnt,
  input  logic                            cnt_clr
);

  localparam int PW = $clog2(WBUF_DEPTH);
  localparam int LW = PW + 1;

  typedef enum logic [1:0] {
    OWN_CORE,
    OWN_ACC_RD,
    OWN_ACC_WR,
    OWN_IDLE
  } owner_e;

  logic [AW-1:0]    wb_addr_q [WBUF_DEPTH];
  logic [15:0]      wb_data_q [WBUF_DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             rd_pend_q, rd_pend_d;
  logic [AW-1:0]    rd_addr_q, rd_addr_d;
  logic             rvalid_q, rvalid_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  owner_e owner;
  logic   fifo_empty;
  logic   fifo_full;
  logic   push;
  logic   pop;
  logic   rd_accept;
  logic   rd_issue;

  // A read is only taken with the FIFO empty, so it can never overtake a posted write.
  always_comb begin
    fifo_empty = (level_q == '0);
    fifo_full  = (level_q == LW'(WBUF_DEPTH));
    acc_ready  = !rd_pend_q && (acc_we ? !fifo_full : fifo_empty);
    push       = acc_valid && acc_ready && acc_we;
    rd_accept  = acc_valid && acc_ready && !acc_we;
    if (!cpu_cen) begin
      owner = OWN_CORE;
    end else if (rd_pend_q) begin
      owner = OWN_ACC_RD;
    end else if (!fifo_empty) begin
      owner = OWN_ACC_WR;
    end else begin
      owner = OWN_IDLE;
    end
    rd_issue = (owner == OWN_ACC_RD);
    pop      = (owner == OWN_ACC_WR);
  end

  always_comb begin
    ram_addr = cpu_addr;
    ram_cen  = cpu_cen;
    ram_wen  = cpu_wen;
    ram_din  = cpu_din;
    case (owner)
      OWN_ACC_RD: begin
        ram_cen  = 1'b0;
        ram_wen  = 2'b11;
        ram_addr = rd_addr_q;
      end
      OWN_ACC_WR: begin
        ram_cen  = 1'b0;
        ram_wen  = 2'b00;
        ram_addr = wb_addr_q[rd_ptr_q];
        ram_din  = wb_data_q[rd_ptr_q];
      end
      OWN_IDLE: begin
        ram_cen = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_comb begin
    wr_ptr_d  = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d  = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    level_d   = level_q + LW'(push) - LW'(pop);
    rd_pend_d = rd_pend_q;
    rd_addr_d = rd_addr_q;
    if (rd_accept) begin
      rd_pend_d = 1'b1;
      rd_addr_d = acc_addr;
    end else if (rd_issue) begin
      rd_pend_d = 1'b0;
    end
    rvalid_d = rd_issue;
    stall_d  = stall_q;
    if (cnt_clr) begin
      stall_d = '0;
    end else if (!cpu_cen && (rd_pend_q || !fifo_empty) && !(&stall_q)) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      rd_pend_q <= 1'b0;
      rd_addr_q <= '0;
      rvalid_q  <= 1'b0;
      stall_q   <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      rd_pend_q <= rd_pend_d;
      rd_addr_q <= rd_addr_d;
      rvalid_q  <= rvalid_d;
      stall_q   <= stall_d;
    end
  end

  // Entry storage needs no reset: only slots between the pointers are ever read.
  always_ff @(posedge mclk) begin
    if (push) begin
      wb_addr_q[wr_ptr_q] <= acc_addr;
      wb_data_q[wr_ptr_q] <= acc_wdata;
    end
  end

  assign cpu_dout   = ram_dout;
  assign acc_rvalid = rvalid_q;
  assign acc_rdata  = rvalid_q ? ram_dout : '0;
  assign wbuf_level = level_q;
  assign stall_cnt  = stall_q;

endmodule

// File: tb/tb_fft_dmem_arbiter.sv
// tb/tb_fft_dmem_arbiter.sv - scoreboard bench for fft_dmem_arbiter
// Model: posted-write queue, single outstanding read, shadow memory; monitor pops read and core returns.
module tb_fft_dmem_arbiter;
  localparam int AW    = 10;
  localparam int DEPTH = 4;
  localparam int CNT_W = 8;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam int SMAX  = (1 << CNT_W) - 1;

  logic             mclk;
  logic             reset_n;
  logic [AW-1:0]    cpu_addr;
  logic             cpu_cen;
  logic [1:0]       cpu_wen;
  logic [15:0]      cpu_din;
  logic [15:0]      cpu_dout;
  logic             acc_valid;
  logic             acc_ready;
  logic             acc_we;
  logic [AW-1:0]    acc_addr;
  logic [15:0]      acc_wdata;
  logic             acc_rvalid;
  logic [15:0]      acc_rdata;
  logic [AW-1:0]    ram_addr;
  logic             ram_cen;
  logic [1:0]       ram_wen;
  logic [15:0]      ram_din;
  logic [15:0]      ram_dout;
  logic [LW-1:0]    wbuf_level;
  logic [CNT_W-1:0] stall_cnt;
  logic             cnt_clr;

  fft_dmem_arbiter #(.AW(AW), .WBUF_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .mclk(mclk), .reset_n(reset_n),
    .cpu_addr(cpu_addr), .cpu_cen(cpu_cen), .cpu_wen(cpu_wen), .cpu_din(cpu_din), .cpu_dout(cpu_dout),
    .acc_valid(acc_valid), .acc_ready(acc_ready), .acc_we(acc_we), .acc_addr(acc_addr),
    .acc_wdata(acc_wdata), .acc_rvalid(acc_rvalid), .acc_rdata(acc_rdata),
    .ram_addr(ram_addr), .ram_cen(ram_cen), .ram_wen(ram_wen), .ram_din(ram_din), .ram_dout(ram_dout),
    .wbuf_level(wbuf_level), .stall_cnt(stall_cnt), .cnt_clr(cnt_clr)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  logic [15:0] mem [0:(1<<AW)-1];
  always @(posedge mclk) begin
    if (!ram_cen) begin
      if (ram_wen == 2'b11) begin
        ram_dout <= mem[ram_addr];
      end else begin
        if (!ram_wen[0]) mem[ram_addr][7:0]  <= ram_din[7:0];
        if (!ram_wen[1]) mem[ram_addr][15:8] <= ram_din[15:8];
      end
    end
  end

  typedef struct packed {
    logic [AW-1:0] a;
    logic [15:0]   d;
  } wr_t;

  logic [15:0]   ref_mem [0:(1<<AW)-1];
  wr_t           wq[$];
  logic [15:0]   rdq[$];
  bit            rd_out;
  logic [AW-1:0] rd_out_addr;
  int            exp_stall;
  bit            track_writes;
  bit            mon_issued;
  bit            exp_cpu_v;
  logic [15:0]   exp_cpu_d;
  int            n_checks;
  int            n_err;
  bit            s_ready;
  bit            s_acc;
  logic          s_rvalid;
  logic [15:0]   s_rdata;
  int            s_level;
  int            s_stall;
  int            peak_level;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle(input logic c_cen, input logic [1:0] c_wen, input logic [AW-1:0] c_addr,
                       input logic [15:0] c_din, input logic a_v, input logic a_we,
                       input logic [AW-1:0] a_addr, input logic [15:0] a_wd, input logic clr);
    bit  busy_acc;
    bit  mready;
    wr_t w;
    @(negedge mclk);
    cpu_cen = c_cen; cpu_wen = c_wen; cpu_addr = c_addr; cpu_din = c_din;
    acc_valid = a_v; acc_we = a_we; acc_addr = a_addr; acc_wdata = a_wd; cnt_clr = clr;
    #1;
    s_ready  = acc_ready;
    s_acc    = a_v && acc_ready;
    s_rvalid = acc_rvalid;
    s_rdata  = acc_rdata;
    s_level  = int'(wbuf_level);
    s_stall  = int'(stall_cnt);
    if (s_level > peak_level) peak_level = s_level;
    mready = !rd_out && (a_we ? (wq.size() < DEPTH) : (wq.size() == 0));
    chk("wbuf_level", 32'(wbuf_level), 32'(wq.size()));
    chk("acc_ready", 32'(acc_ready), 32'(mready));
    chk("stall_cnt", 32'(stall_cnt), 32'(exp_stall));
    busy_acc   = rd_out || (wq.size() != 0);
    mon_issued = 1'b0;
    if (!c_cen) begin
      chk("ram_core", 32'({ram_cen, ram_wen, ram_addr, ram_din}), 32'({1'b0, c_wen, c_addr, c_din}));
    end else if (rd_out) begin
      chk("ram_acc_rd", 32'({ram_cen, ram_wen, ram_addr}), 32'({3'b011, rd_out_addr}));
      rd_out     = 1'b0;
      mon_issued = 1'b1;
    end else if (wq.size() != 0) begin
      w = wq.pop_front();
      chk("ram_acc_wr", 32'({ram_cen, ram_wen, ram_addr, ram_din}), 32'({3'b000, w.a, w.d}));
    end else begin
      chk("ram_idle", 32'(ram_cen), 32'd1);
    end
    if (clr) exp_stall = 0;
    else if (!c_cen && busy_acc && exp_stall != SMAX) exp_stall++;
    if (s_acc) begin
      if (a_we) begin
        w.a = a_addr; w.d = a_wd;
        wq.push_back(w);
        if (track_writes) ref_mem[a_addr] = a_wd;
      end else begin
        rd_out      = 1'b1;
        rd_out_addr = a_addr;
        rdq.push_back(ref_mem[a_addr]);
      end
    end
    exp_cpu_v = 1'b0;
    if (!c_cen) begin
      if (c_wen == 2'b11) begin
        exp_cpu_v = 1'b1;
        exp_cpu_d = ref_mem[c_addr];
      end else begin
        if (!c_wen[0]) ref_mem[c_addr][7:0]  = c_din[7:0];
        if (!c_wen[1]) ref_mem[c_addr][15:8] = c_din[15:8];
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 2'b11, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic core_rd(input logic [AW-1:0] a);
    cycle(1'b0, 2'b11, a, '0, 1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic do_reset(input bit rv_before);
    @(negedge mclk);
    chk("rvalid_before_reset", 32'(acc_rvalid), 32'(rv_before));
    cpu_cen = 1'b1; cpu_wen = 2'b11; acc_valid = 1'b0; cnt_clr = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("rst_rvalid", 32'(acc_rvalid), 32'd0);
    chk("rst_rdata", 32'(acc_rdata), 32'd0);
    chk("rst_level", 32'(wbuf_level), 32'd0);
    chk("rst_stall", 32'(stall_cnt), 32'd0);
    chk("rst_ram_cen", 32'(ram_cen), 32'd1);
    wq.delete(); rdq.delete();
    rd_out = 1'b0; exp_stall = 0; mon_issued = 1'b0; exp_cpu_v = 1'b0;
    repeat (2) @(negedge mclk);
    reset_n = 1'b1;
  endtask

  always @(posedge mclk) begin
    #2;
    if (reset_n) begin
      chk("rvalid_timing", 32'(acc_rvalid), 32'(mon_issued));
      if (acc_rvalid) begin
        if (rdq.size() > 0) chk("acc_rdata", 32'(acc_rdata), 32'(rdq.pop_front()));
        else chk("rd_outstanding", 32'(rdq.size()), 32'd1);
      end
      if (exp_cpu_v) chk("cpu_dout", 32'(cpu_dout), 32'(exp_cpu_d));
    end
  end

  initial begin
    logic          r_cen, r_av, r_we, r_clr;
    logic [1:0]    r_wen;
    logic [AW-1:0] r_caddr, r_aaddr;
    logic [15:0]   r_cdin, r_awd;
    int            tries;

    n_checks = 0; n_err = 0; track_writes = 1'b1; peak_level = 0;
    reset_n = 1'b0; cpu_cen = 1'b1; cpu_wen = 2'b11; cpu_addr = '0; cpu_din = '0;
    acc_valid = 1'b0; acc_we = 1'b0; acc_addr = '0; acc_wdata = '0; cnt_clr = 1'b0;
    rd_out = 1'b0; exp_stall = 0;
    do_reset(1'b0);

    for (int i = 0; i < (1 << AW); i++)
      cycle(1'b0, 2'b00, AW'(i), 16'($urandom), 1'b0, 1'b0, '0, '0, 1'b0);

    // 1: core-only read
    cycle(1'b0, 2'b00, 10'h010, 16'hBEEF, 1'b0, 1'b0, '0, '0, 1'b0);
    core_rd(10'h010);
    idle(1);
    chk("t1_rvalid", 32'(s_rvalid), 32'd0);

    // 2: back-to-back posted writes with the core idle
    peak_level = 0;
    cycle(1'b1, 2'b11, '0, '0, 1'b1, 1'b1, 10'h020, 16'h1111, 1'b0);
    chk("t2_acc0", 32'(s_acc), 32'd1);
    cycle(1'b1, 2'b11, '0, '0, 1'b1, 1'b1, 10'h021, 16'h2222, 1'b0);
    chk("t2_acc1", 32'(s_acc), 32'd1);
    cycle(1'b1, 2'b11, '0, '0, 1'b1, 1'b1, 10'h022, 16'h3333, 1'b0);
    chk("t2_acc2", 32'(s_acc), 32'd1);
    idle(3);
    chk("t2_peak", 32'(peak_level), 32'd1);
    chk("t2_level0", 32'(s_level), 32'd0);
    core_rd(10'h020); core_rd(10'h021); core_rd(10'h022);

    // 3: read held off by a busy core for five cycles
    cycle(1'b0, 2'b00, 10'h030, 16'hCAFE, 1'b0, 1'b0, '0, '0, 1'b1);
    cycle(1'b0, 2'b11, 10'h300, '0, 1'b1, 1'b0, 10'h030, '0, 1'b0);
    chk("t3_accept", 32'(s_acc), 32'd1);
    for (int i = 0; i < 5; i++) core_rd(AW'(10'h300 + i));
    idle(1);
    chk("t3_rvalid_issue", 32'(s_rvalid), 32'd0);
    idle(1);
    chk("t3_rvalid", 32'(s_rvalid), 32'd1);
    chk("t3_rdata", 32'(s_rdata), 32'h0000CAFE);
    chk("t3_stall", 32'(s_stall), 32'd5);

    // 4: fill the FIFO under a busy core, then RAW through it
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 2'b11, 10'h301, '0, 1'b1, 1'b1, AW'(10'h041 + i), 16'($urandom), 1'b0);
      chk("t4_fill", 32'(s_acc), 32'd1);
    end
    cycle(1'b0, 2'b11, 10'h301, '0, 1'b1, 1'b1, 10'h040, 16'hA5A5, 1'b0);
    chk("t4_full_ready", 32'(s_ready), 32'd0);
    chk("t4_level4", 32'(s_level), 32'd4);
    tries = 0;
    do begin
      cycle(1'b1, 2'b11, '0, '0, 1'b1, 1'b1, 10'h040, 16'hA5A5, 1'b0);
      tries++;
    end while (!s_acc && tries < 10);
    chk("t4_wr_accepted", 32'(s_acc), 32'd1);
    tries = 0;
    do begin
      cycle(1'b1, 2'b11, '0, '0, 1'b1, 1'b0, 10'h040, '0, 1'b0);
      tries++;
    end while (!s_acc && tries < 10);
    chk("t4_rd_accepted", 32'(s_acc), 32'd1);
    chk("t4_rd_after_drain", 32'(s_level), 32'd0);
    idle(3);

    // 5: reset with posted writes, with a pending read, and during rvalid
    track_writes = 1'b0;
    for (int i = 0; i < 3; i++)
      cycle(1'b0, 2'b11, 10'h302, '0, 1'b1, 1'b1, AW'(10'h050 + i), 16'hDEAD, 1'b0);
    core_rd(10'h302);
    chk("t5_level3", 32'(s_level), 32'd3);
    do_reset(1'b0);
    track_writes = 1'b1;
    idle(4);
    core_rd(10'h050); core_rd(10'h051); core_rd(10'h052);
    cycle(1'b0, 2'b11, 10'h303, '0, 1'b1, 1'b0, 10'h060, '0, 1'b0);
    core_rd(10'h303);
    do_reset(1'b0);
    idle(4);
    cycle(1'b1, 2'b11, '0, '0, 1'b1, 1'b0, 10'h061, '0, 1'b0);
    idle(1);
    do_reset(1'b1);
    idle(2);

    // 6: stall counter saturation and clear priority
    cycle(1'b0, 2'b11, 10'h304, '0, 1'b1, 1'b1, 10'h070, 16'h7070, 1'b1);
    for (int i = 0; i < SMAX + 5; i++) core_rd(AW'(10'h200 + (i % 256)));
    chk("t6_saturated", 32'(s_stall), 32'(SMAX));
    cycle(1'b0, 2'b11, 10'h305, '0, 1'b0, 1'b0, '0, '0, 1'b1);
    core_rd(10'h305);
    chk("t6_cleared", 32'(s_stall), 32'd0);
    idle(3);

    // randomized traffic: core in the upper half, accelerator on a small hot window
    for (int i = 0; i < 3000; i++) begin
      r_cen   = 1'($urandom_range(0, 1));
      r_wen   = 2'($urandom_range(0, 3));
      r_caddr = AW'($urandom_range(512, 1023));
      r_cdin  = 16'($urandom);
      r_av    = ($urandom_range(0, 3) != 0);
      r_we    = ($urandom_range(0, 2) != 0);
      r_aaddr = AW'($urandom_range(0, 31));
      r_awd   = 16'($urandom);
      r_clr   = ($urandom_range(0, 63) == 0);
      cycle(r_cen, r_wen, r_caddr, r_cdin, r_av, r_we, r_aaddr, r_awd, r_clr);
    end
    tries = 0;
    while ((wq.size() != 0 || rd_out) && tries < 40) begin
      idle(1);
      tries++;
    end
    chk("drain_done", 32'(wq.size() == 0 && !rd_out), 32'd1);
    idle(3);
    chk("rdq_empty", 32'(rdq.size()), 32'd0);
    for (int i = 0; i < (1 << AW); i++) core_rd(AW'(i));
    idle(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
